// File: rtl/nbit_addsub_seq.sv
// Iterative N-bit adder/subtractor. It processes CHUNK bits per cycle, starting
// with the least-significant chunk, and keeps the inter-chunk carry in a register.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// The producer holds its data until then, and ready does not depend on valid.
module nbit_addsub_seq #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf,
    output logic         zero
);

    localparam int NCHUNK = N / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // The state register is kept as a named signal so checkers can observe the FSM.
    state_t state;
    state_t state_next;

    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;        // effective operand: b for add, ~b for subtract
    logic             op_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_chunk;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic [N-1:0]     sum_next;

    // One chunk of the ripple: select the current slice, add it, and merge it into the result.
    always_comb begin
        accept     = in_valid && (state == IDLE);
        last_chunk = (cnt == CNT_W'(NCHUNK - 1));
        a_chunk    = a_q[int'(cnt) * CHUNK +: CHUNK];
        b_chunk    = b_q[int'(cnt) * CHUNK +: CHUNK];
        chunk_res  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        sum_next   = sum;
        sum_next[int'(cnt) * CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
    end

    // FSM state register. Reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then build the result one chunk per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= op ? ~b : b;
            op_q    <= op;
            carry_q <= c_in;
            cnt     <= '0;
        end else if (state == CALC) begin
            sum     <= sum_next;
            carry_q <= chunk_res[CHUNK];
            cnt     <= cnt + 1'b1;
            if (last_chunk) begin
                // A subtract reports a borrow, which is the inverted final carry.
                c_out <= chunk_res[CHUNK] ^ op_q;
                // b_q is already inverted for subtract, so one rule covers both ops:
                // the operands have the same sign and the result sign differs from it.
                ovf   <= (a_q[N-1] == b_q[N-1]) && (sum_next[N-1] != a_q[N-1]);
                zero  <= (sum_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_nbit_addsub_seq.sv
// Bench for nbit_addsub_seq. Four instances (CHUNK = 1, 4, 8, 32) share their inputs.
// Directed vectors with hand-computed results target the CHUNK=8 and CHUNK=32 instances.
// A random sweep checks all four instances against a reference model.
module tb_nbit_addsub_seq;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        c_in = 1'b0;
    logic        op = 1'b0;

    logic [3:0]  in_ready_w;
    logic [3:0]  out_valid_w;
    logic [3:0]  c_out_w;
    logic [3:0]  ovf_w;
    logic [3:0]  zero_w;
    logic [31:0] sum_w [4];

    int n_tests = 0;
    int n_fail  = 0;

    // Latched results per instance from the most recent run_op.
    logic [31:0] r_sum [4];
    logic [3:0]  r_cout;
    logic [3:0]  r_ovf;
    logic [3:0]  r_zero;
    int          r_lat [4];

    function automatic int ch_of(input int i);
        case (i)
            0: return 1;
            1: return 4;
            2: return 8;
            default: return 32;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int CH = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
        nbit_addsub_seq #(.N(N), .CHUNK(CH)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .a         (a),
            .b         (b),
            .c_in      (c_in),
            .op        (op),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .sum       (sum_w[g]),
            .c_out     (c_out_w[g]),
            .ovf       (ovf_w[g]),
            .zero      (zero_w[g])
        );
    end

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation to all instances, collect each result, and check it against
    // the model. With hold > 0, the CHUNK=8 instance is kept in DONE for hold cycles
    // while a conflicting operation is presented on the inputs.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic tcin, input logic top_, input int hold);
        logic [32:0] full;
        logic [31:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
        logic [3:0]  seen;
        int          guard;
        int          cyc;
        int          hold_left;

        full   = {1'b0, ta} + {1'b0, (top_ ? ~tb_v : tb_v)} + {32'd0, tcin};
        e_sum  = full[31:0];
        e_cout = full[32] ^ top_;
        e_ovf  = top_ ? ((ta[31] != tb_v[31]) && (e_sum[31] != ta[31]))
                      : ((ta[31] == tb_v[31]) && (e_sum[31] != ta[31]));

        out_ready = 1'b1;
        guard = 0;
        while (in_ready_w != 4'hF && guard < 100) begin
            tick();
            guard++;
        end
        check("idle_wait", {63'd0, in_ready_w == 4'hF}, 64'd1);

        a = ta; b = tb_v; c_in = tcin; op = top_;
        if (hold > 0) out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;

        seen = '0;
        cyc = 0;
        hold_left = hold;
        while (seen != 4'hF && cyc < 80) begin
            tick();
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (!seen[i] && out_valid_w[i]) begin
                    seen[i]   = 1'b1;
                    r_sum[i]  = sum_w[i];
                    r_cout[i] = c_out_w[i];
                    r_ovf[i]  = ovf_w[i];
                    r_zero[i] = zero_w[i];
                    r_lat[i]  = cyc;
                end
            end
            if (seen[2] && hold_left > 0) begin
                check("hold_valid", {63'd0, out_valid_w[2]}, 64'd1);
                check("hold_ready", {63'd0, in_ready_w[2]}, 64'd0);
                check("hold_sum", {32'd0, sum_w[2]}, {32'd0, r_sum[2]});
                check("hold_flags", {61'd0, c_out_w[2], ovf_w[2], zero_w[2]},
                      {61'd0, r_cout[2], r_ovf[2], r_zero[2]});
                // A competing request while busy must be ignored.
                a = 32'h1234_5678; b = 32'h0F0F_0F0F; op = ~top_; in_valid = 1'b1;
                hold_left--;
                if (hold_left == 0) begin
                    in_valid  = 1'b0;
                    out_ready = 1'b1;
                end
            end
        end

        for (int i = 0; i < 4; i++) begin
            if (!seen[i]) begin
                check($sformatf("timeout_c%0d", ch_of(i)), 64'd0, 64'd1);
            end else begin
                check($sformatf("sum_c%0d", ch_of(i)), {32'd0, r_sum[i]}, {32'd0, e_sum});
                check($sformatf("cout_c%0d", ch_of(i)), {63'd0, r_cout[i]}, {63'd0, e_cout});
                check($sformatf("ovf_c%0d", ch_of(i)), {63'd0, r_ovf[i]}, {63'd0, e_ovf});
                check($sformatf("zero_c%0d", ch_of(i)), {63'd0, r_zero[i]}, {63'd0, e_sum == 32'd0});
                check($sformatf("lat_c%0d", ch_of(i)), 64'(r_lat[i]), 64'(32 / ch_of(i)));
            end
        end
    endtask

    initial begin
        // Reset while a request is presented: the request must not be accepted.
        rst = 1'b1;
        in_valid = 1'b1;
        a = 32'hDEAD_BEEF; b = 32'h1;
        tick(); tick(); tick();
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        check("rst_in_ready", {60'd0, in_ready_w}, 64'hF);
        check("rst_out_valid", {60'd0, out_valid_w}, 64'h0);
        check("rst_sum", {32'd0, sum_w[2]}, 64'd0);
        check("rst_flags", {61'd0, c_out_w[2], ovf_w[2], zero_w[2]}, 64'd0);

        // Add with wrap to zero. The latency is checked inside run_op (4 for CHUNK=8).
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 0);
        check("v1_sum", {32'd0, r_sum[2]}, 64'h0);
        check("v1_flags", {61'd0, r_cout[2], r_ovf[2], r_zero[2]}, {61'd0, 3'b101});
        check("v1_lat", 64'(r_lat[2]), 64'd4);

        // Subtract with borrow.
        run_op(32'd5, 32'd7, 1'b1, 1'b1, 0);
        check("v2_sum", {32'd0, r_sum[2]}, 64'hFFFF_FFFE);
        check("v2_flags", {61'd0, r_cout[2], r_ovf[2], r_zero[2]}, {61'd0, 3'b100});

        // Subtract with signed overflow.
        run_op(32'h8000_0000, 32'd1, 1'b1, 1'b1, 0);
        check("v3_sum", {32'd0, r_sum[2]}, 64'h7FFF_FFFF);
        check("v3_flags", {61'd0, r_cout[2], r_ovf[2], r_zero[2]}, {61'd0, 3'b010});

        // Add with signed overflow, and a 5-cycle stall on out_ready.
        run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 5);
        check("v4_sum", {32'd0, r_sum[2]}, 64'h8000_0000);
        check("v4_flags", {61'd0, r_cout[2], r_ovf[2], r_zero[2]}, {61'd0, 3'b010});
        check("v4_idle_ready", {63'd0, in_ready_w[2]}, 64'd1);
        check("v4_idle_valid", {63'd0, out_valid_w[2]}, 64'd0);
        check("v4_retained", {32'd0, sum_w[2]}, 64'h8000_0000);

        // Reset while chunk 2 is being processed.
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c_in = 1'b1; op = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", {63'd0, out_valid_w[2]}, 64'd0);
        check("abort_ready", {63'd0, in_ready_w[2]}, 64'd1);
        check("abort_sum", {32'd0, sum_w[2]}, 64'd0);
        run_op(32'd3, 32'd4, 1'b0, 1'b0, 0);
        check("post_abort_sum", {32'd0, r_sum[2]}, 64'd7);
        check("post_abort_flags", {61'd0, r_cout[2], r_ovf[2], r_zero[2]}, 64'd0);

        // Single-chunk build: result one cycle after accept.
        run_op(32'd10, 32'd20, 1'b1, 1'b0, 0);
        check("c32_sum", {32'd0, r_sum[3]}, 64'd31);
        check("c32_lat", 64'(r_lat[3]), 64'd1);

        // Random sweep across all chunk sizes.
        for (int k = 0; k < 12; k++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        // Equal operands on subtract give zero, with no borrow when c_in=1.
        run_op(32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b1, 1'b1, 0);
        check("eq_sub_zero", {63'd0, r_zero[2]}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
